// File: rtl/alu_issue.sv
// Issue stage in front of the 3-bit-opcode ALU.
// Holds one decoded instruction, resolves its operands from the stored register-file values, the
// immediate and the f1/f2 producer paths, and presents them to the ALU with a valid/ready handshake.
// Optional feature: define ALU_ISSUE_FWD_EN to enable the f1/f2 forwarding muxes. Without it the
// entry stalls on any pending producer and picks the value up through writeback snooping.
module alu_issue #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned REGW  = 5
) (
  input  logic             clk,
  input  logic             rst,
  // decode side
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [REGW-1:0]  in_rs1,
  input  logic [REGW-1:0]  in_rs2,
  input  logic [WIDTH-1:0] in_v1,
  input  logic [WIDTH-1:0] in_v2,
  input  logic [WIDTH-1:0] in_imm,
  input  logic             in_use_imm,
  input  logic [2:0]       in_f,
  input  logic [REGW-1:0]  in_rd,
  input  logic             in_we,
  input  logic             flush,
  // EX/MEM producer
  input  logic             f1_we,
  input  logic [REGW-1:0]  f1_rd,
  input  logic [WIDTH-1:0] f1_data,
  input  logic             f1_rdy,
  // MEM/WB producer, also this cycle's register-file write
  input  logic             f2_we,
  input  logic [REGW-1:0]  f2_rd,
  input  logic [WIDTH-1:0] f2_data,
  // ALU side
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_f,
  output logic [REGW-1:0]  out_rd,
  output logic             out_we
);

  logic             full_q, full_d;
  logic [REGW-1:0]  rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [WIDTH-1:0] v1_q, v1_d, v2_q, v2_d, imm_q, imm_d;
  logic             use_imm_q, use_imm_d, we_q, we_d;
  logic [2:0]       f_q, f_d;

  // Producer matches against the held sources; x0 never matches, an unused rs2 never matches.
  logic f1_hit1, f1_hit2, f2_hit1, f2_hit2;
  // Same-cycle writeback matches against the incoming sources, for the capture edge.
  logic cap_hit1, cap_hit2;
  logic hazard, release_c, accept;
  logic [WIDTH-1:0] a_res, b_res;

  // Source/producer match decode for the held entry and the incoming instruction
  always_comb begin
    f1_hit1  = f1_we && (f1_rd == rs1_q) && (rs1_q != '0);
    f1_hit2  = f1_we && (f1_rd == rs2_q) && (rs2_q != '0) && !use_imm_q;
    f2_hit1  = f2_we && (f2_rd == rs1_q) && (rs1_q != '0);
    f2_hit2  = f2_we && (f2_rd == rs2_q) && (rs2_q != '0) && !use_imm_q;
    cap_hit1 = f2_we && (f2_rd == in_rs1) && (in_rs1 != '0);
    cap_hit2 = f2_we && (f2_rd == in_rs2) && (in_rs2 != '0) && !in_use_imm;
  end

`ifdef ALU_ISSUE_FWD_EN
  // Forwarding muxes: f1 beats f2 beats the stored value; only a not-ready f1 stalls
  always_comb begin
    hazard = full_q && (f1_hit1 || f1_hit2) && !f1_rdy;
    if (rs1_q == '0)  a_res = '0;
    else if (f1_hit1) a_res = f1_data;
    else if (f2_hit1) a_res = f2_data;
    else              a_res = v1_q;
    if (rs2_q == '0)  b_res = '0;
    else if (f1_hit2) b_res = f1_data;
    else if (f2_hit2) b_res = f2_data;
    else              b_res = v2_q;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{f1_data, f1_rdy};

  // No forwarding: wait out every pending producer, the snoop delivers its value
  always_comb begin
    hazard = full_q && (f1_hit1 || f1_hit2 || f2_hit1 || f2_hit2);
    a_res  = (rs1_q == '0) ? '0 : v1_q;
    b_res  = (rs2_q == '0) ? '0 : v2_q;
  end
`endif

  // Handshake and outputs; an empty entry drives all zeros
  always_comb begin
    out_valid = full_q && !hazard;
    release_c = out_valid && out_ready;
    in_ready  = !full_q || release_c;
    accept    = in_valid && in_ready && !flush;
    alu_a     = full_q ? a_res : '0;
    alu_b     = !full_q ? '0 : (use_imm_q ? imm_q : b_res);
    alu_f     = full_q ? f_q : 3'd0;
    out_rd    = full_q ? rd_q : '0;
    out_we    = full_q && we_q;
  end

  // Next entry: flush > accept (with capture snoop) > release > hold (with snoop)
  always_comb begin
    full_d    = full_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    f_d       = f_q;
    rd_d      = rd_q;
    we_d      = we_q;
    if (flush) begin
      full_d = 1'b0;
    end else if (accept) begin
      full_d    = 1'b1;
      rs1_d     = in_rs1;
      rs2_d     = in_rs2;
      v1_d      = cap_hit1 ? f2_data : in_v1;
      v2_d      = cap_hit2 ? f2_data : in_v2;
      imm_d     = in_imm;
      use_imm_d = in_use_imm;
      f_d       = in_f;
      rd_d      = in_rd;
      we_d      = in_we;
    end else if (release_c) begin
      full_d = 1'b0;
    end else if (full_q) begin
      if (f2_hit1) v1_d = f2_data;
      if (f2_hit2) v2_d = f2_data;
    end
  end

  // Entry register with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q    <= 1'b0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      v1_q      <= '0;
      v2_q      <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
      f_q       <= 3'd0;
      rd_q      <= '0;
      we_q      <= 1'b0;
    end else begin
      full_q    <= full_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
      f_q       <= f_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
    end
  end

endmodule
